hwjsoc_multi_timer: RTL and testbench
=====================================

# hwjsoc_multi_timer

Parametrised multi-channel interval timer, the next-generation HwJSoC system timer. NUM_CH independent down-counters of CNT_W bits, each with a programmable prescaler, one-shot or continuous mode, snapshot capture and a per-channel interrupt. It sits on the Avalon-MM peripheral bus beside the Nios II and drives a per-channel IRQ vector plus a combined IRQ line.

## Interface
- NUM_CH, 4: channel count, 1..8
- CNT_W, 32: counter and period width, 16..32
- PRE_W, 8: prescaler width
- DEFAULT_PERIOD, 99999: reset value of every PERIOD and counter
- clk  in  1  system clock
- reset  in  1  reset; one clock, reset is synchronous and active-high
- address  in  $clog2(NUM_CH)+2  address = {channel, reg[1:0]}; channel ≥ NUM_CH is unmapped
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- irq_vec  out  NUM_CH  per-channel interrupt, TO & ITO
- irq  out  1  OR of irq_vec

## Operation
- Write strobe: wr = chipselect & ~write_n. All writes take effect at the next clk edge.
- Per-channel registers:
  - reg 0 STATUS: bit0 TO, bit1 RUN. Any write clears TO.
  - reg 1 CONTROL: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP (START and STOP self-clear and read as 0), bits[8+PRE_W-1:8] PRESCALE.
  - reg 2 PERIOD: bits[CNT_W-1:0]; upper bits read 0.
  - reg 3 SNAPSHOT: a write copies the counter into SNAP; a read returns SNAP.
- Unmapped channel: write ignored, read returns 0.
- Prescaler:
  - Per-channel pre_cnt counts 0..PRESCALE; tick when pre_cnt == PRESCALE and RUN. PRESCALE=0 gives a tick every cycle.
  - pre_cnt clears on START and on a PERIOD write.
- Counter, on tick:
  - If count == 0: timeout event. Set TO, reload PERIOD, and clear RUN if CONT=0.
  - Else count decrements by 1.
  - Period N therefore gives a timeout every (N+1)·(PRESCALE+1) cycles.
- PERIOD write: loads the new value into both PERIOD and count, clears RUN, clears pre_cnt.
- START and STOP in the same write: START wins.
- START while already running: pre_cnt restarts; count is unchanged.
- Status write in the same cycle as a timeout: TO ends set (an event is never lost).
- PERIOD write in the same cycle as a timeout: the PERIOD write wins; TO is still set.
- Snapshot write in the same cycle as a tick: captures the pre-tick count.
- Channels are fully independent; the bus can access only one channel per cycle.

## Timing
- Reset values:
  - readdata = 0, irq_vec = 0, irq = 0.
  - Per channel: TO = 0, RUN = 0, CONTROL = 0, PERIOD = count = DEFAULT_PERIOD, SNAP = 0, pre_cnt = 0.
- Read latency is 1 cycle: readdata is registered every cycle from the address muxed during that cycle; no wait states.
- TO and irq_vec rise on the clock edge of the tick where count == 0.
- irq_vec drops the cycle after a STATUS write, or after a CONTROL write with ITO = 0.
- RUN goes to 1 on the edge after a START write; the first tick occurs PRESCALE+1 cycles later.
- Reset asserted mid-count returns all state to reset values on the next edge.

## Structure
- Package hwjsoc_timer_pkg holds:
  - register offsets: REG_STATUS = 0, REG_CONTROL = 1, REG_PERIOD = 2, REG_SNAP = 3;
  - CONTROL bit indices: ITO, CONT, START, STOP, PRE_LSB = 8;
  - STATUS bit indices: TO, RUN.
- Sub-module hwjsoc_timer_channel (parameters CNT_W, PRE_W, DEFAULT_PERIOD) holds the prescaler, counter, TO/RUN, CONTROL, PERIOD and SNAP for one channel.
- The top level generates NUM_CH channels, decodes the address, muxes readdata and ORs the IRQs.

## Test plan
- Reset, then read ch0 PERIOD → 99999. Read STATUS → 0. irq = 0.
- Continuous mode: ch1 PERIOD = 9, CONTROL = CONT|ITO|START → TO and irq_vec[1] at cycle 10 after RUN, then every 10 cycles. STATUS write clears irq the next cycle.
- One-shot with prescaler: ch2 PERIOD = 3, PRESCALE = 4, START → single timeout after 20 cycles; RUN = 0 afterwards; count reloaded to 3.
- Timeout edge collision: STATUS write in the exact timeout cycle → TO reads 1.
- Snapshot: ch0 running from PERIOD = 1000; snapshot write 100 cycles after RUN → SNAP = 900. PERIOD write = 50 → RUN = 0, count = 50.
- Multi-channel: NUM_CH = 8, CNT_W = 16, channels 0 and 7 with different periods → independent IRQs. Write to channel 7's address space touches no other channel.

Source files
------------

// File: rtl/hwjsoc_timer_pkg.sv
// Shared definitions for the multi-channel interval timer: register map,
// CONTROL/STATUS bit positions and the bus address width helper.
package hwjsoc_timer_pkg;

    localparam int BUS_W = 32;

    // Register offsets within a channel's address window
    localparam logic [1:0] REG_STATUS  = 2'd0;
    localparam logic [1:0] REG_CONTROL = 2'd1;
    localparam logic [1:0] REG_PERIOD  = 2'd2;
    localparam logic [1:0] REG_SNAP    = 2'd3;

    // CONTROL bit indices
    localparam int ITO     = 0;
    localparam int CONT    = 1;
    localparam int START   = 2;
    localparam int STOP    = 3;
    localparam int PRE_LSB = 8;

    // STATUS bit indices
    localparam int TO  = 0;
    localparam int RUN = 1;

    // Address is {channel, reg[1:0]}
    function automatic int addr_width(input int num_ch);
        return $clog2(num_ch) + 2;
    endfunction

endpackage

// File: rtl/hwjsoc_multi_timer_if.sv
// Avalon-MM slave bus bundle for the multi-channel timer.
interface hwjsoc_multi_timer_if
    import hwjsoc_timer_pkg::*;
#(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [BUS_W-1:0]  writedata;
    logic [BUS_W-1:0]  readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/hwjsoc_timer_channel.sv
// One timer channel: prescaler, down-counter, TO/RUN flags, CONTROL,
// PERIOD and SNAPSHOT registers. Read data is combinational; the top
// level registers it.
module hwjsoc_timer_channel
    import hwjsoc_timer_pkg::*;
#(
    parameter int CNT_W          = 32,
    parameter int PRE_W          = 8,
    parameter int DEFAULT_PERIOD = 99999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [1:0]       reg_sel,
    input  logic [BUS_W-1:0] wdata,
    output logic [BUS_W-1:0] rd_data,
    output logic             irq
);

    logic             to_q;
    logic             run_q;
    logic             ito_q;
    logic             cont_q;
    logic [PRE_W-1:0] prescale;
    logic [PRE_W-1:0] pre_cnt;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] snap;

    logic wr_status;
    logic wr_control;
    logic wr_period;
    logic wr_snap;
    logic start_req;
    logic stop_req;
    logic tick;
    logic timeout;

    // Bits 4..7 and anything above the register fields are don't-care
    logic unused_wdata;
    assign unused_wdata = ^wdata;

    assign wr_status  = wr && (reg_sel == REG_STATUS);
    assign wr_control = wr && (reg_sel == REG_CONTROL);
    assign wr_period  = wr && (reg_sel == REG_PERIOD);
    assign wr_snap    = wr && (reg_sel == REG_SNAP);
    assign start_req  = wr_control && wdata[START];
    assign stop_req   = wr_control && wdata[STOP];

    assign tick    = run_q && (pre_cnt == prescale);
    assign timeout = tick && (count == '0);

    assign irq = to_q && ito_q;

    // CONTROL fields that persist (START/STOP are strobes only)
    always_ff @(posedge clk) begin
        if (reset) begin
            ito_q    <= 1'b0;
            cont_q   <= 1'b0;
            prescale <= '0;
        end else if (wr_control) begin
            ito_q    <= wdata[ITO];
            cont_q   <= wdata[CONT];
            prescale <= wdata[PRE_LSB +: PRE_W];
        end
    end

    // Prescaler: restarts on START or PERIOD write, wraps on each tick
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (wr_period || start_req) begin
            pre_cnt <= '0;
        end else if (run_q) begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
        end
    end

    // PERIOD register and down-counter; a PERIOD write overrides a tick
    always_ff @(posedge clk) begin
        if (reset) begin
            period <= CNT_W'(DEFAULT_PERIOD);
            count  <= CNT_W'(DEFAULT_PERIOD);
        end else if (wr_period) begin
            period <= wdata[CNT_W-1:0];
            count  <= wdata[CNT_W-1:0];
        end else if (tick) begin
            count <= (count == '0) ? period : count - 1'b1;
        end
    end

    // RUN flag: PERIOD write stops, START beats STOP, one-shot stops on timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            run_q <= 1'b0;
        end else if (wr_period) begin
            run_q <= 1'b0;
        end else if (start_req) begin
            run_q <= 1'b1;
        end else if (stop_req) begin
            run_q <= 1'b0;
        end else if (timeout && !cont_q) begin
            run_q <= 1'b0;
        end
    end

    // TO flag: a timeout in the same cycle as a STATUS write is kept
    always_ff @(posedge clk) begin
        if (reset) begin
            to_q <= 1'b0;
        end else if (timeout) begin
            to_q <= 1'b1;
        end else if (wr_status) begin
            to_q <= 1'b0;
        end
    end

    // Snapshot captures the count as it stands before this edge's tick
    always_ff @(posedge clk) begin
        if (reset) begin
            snap <= '0;
        end else if (wr_snap) begin
            snap <= count;
        end
    end

    // Register read mux for this channel
    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_STATUS: begin
                rd_data[TO]  = to_q;
                rd_data[RUN] = run_q;
            end
            REG_CONTROL: begin
                rd_data[ITO]               = ito_q;
                rd_data[CONT]              = cont_q;
                rd_data[PRE_LSB +: PRE_W]  = prescale;
            end
            REG_PERIOD: rd_data[CNT_W-1:0] = period;
            default:    rd_data[CNT_W-1:0] = snap;
        endcase
    end

endmodule

// File: rtl/hwjsoc_multi_timer.sv
// Multi-channel interval timer on an Avalon-MM slave port. Generates
// NUM_CH channels, decodes {channel, reg} addresses, registers read data
// and combines the per-channel interrupts.
module hwjsoc_multi_timer
    import hwjsoc_timer_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 32,
    parameter int PRE_W          = 8,
    parameter int DEFAULT_PERIOD = 99999
) (
    input  logic                 clk,
    input  logic                 reset,
    hwjsoc_multi_timer_if.slave  bus,
    output logic [NUM_CH-1:0]    irq_vec,
    output logic                 irq
);

    localparam int ADDR_W = addr_width(NUM_CH);

    logic              wr;
    logic [ADDR_W-1:0] ch_sel;
    logic [1:0]        reg_sel;
    logic [BUS_W-1:0]  ch_rd [NUM_CH];
    logic [NUM_CH-1:0] ch_irq;
    logic [BUS_W-1:0]  rd_mux;

    assign wr      = bus.chipselect & ~bus.write_n;
    assign ch_sel  = bus.address >> 2;
    assign reg_sel = bus.address[1:0];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic ch_wr;
        assign ch_wr = wr && (ch_sel == ADDR_W'(g));

        hwjsoc_timer_channel #(
            .CNT_W          (CNT_W),
            .PRE_W          (PRE_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .wr      (ch_wr),
            .reg_sel (reg_sel),
            .wdata   (bus.writedata),
            .rd_data (ch_rd[g]),
            .irq     (ch_irq[g])
        );
    end

    // Select the addressed channel's read data; unmapped channels read 0
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == ADDR_W'(i)) begin
                rd_mux = ch_rd[i];
            end
        end
    end

    // Read data is registered every cycle, giving one cycle of latency
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= rd_mux;
        end
    end

    assign irq_vec = ch_irq;
    assign irq     = |ch_irq;

endmodule

// File: tb/tb_hwjsoc_multi_timer.sv
// Bench for hwjsoc_multi_timer: a 4-channel/32-bit instance and an
// 8-channel/16-bit instance, directed scenarios plus randomized channel
// programming checked against an arithmetic timeout model.
module tb_hwjsoc_multi_timer;
    import hwjsoc_timer_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [3:0] irq_vec4;
    logic       irq4;
    logic [7:0] irq_vec8;
    logic       irq8;

    hwjsoc_multi_timer_if #(.ADDR_W(4)) bus4 ();
    hwjsoc_multi_timer_if #(.ADDR_W(5)) bus8 ();

    hwjsoc_multi_timer dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus4.slave),
        .irq_vec (irq_vec4),
        .irq     (irq4)
    );

    hwjsoc_multi_timer #(
        .NUM_CH         (8),
        .CNT_W          (16),
        .PRE_W          (8),
        .DEFAULT_PERIOD (1000)
    ) dut8 (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus8.slave),
        .irq_vec (irq_vec8),
        .irq     (irq8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step();
    endtask

    task automatic bus_idle();
        bus4.chipselect = 1'b0; bus4.write_n = 1'b1;
        bus8.chipselect = 1'b0; bus8.write_n = 1'b1;
    endtask

    task automatic wr(input int d, input int ch, input int r, input logic [31:0] data);
        if (d == 0) begin
            bus4.address = 4'(ch * 4 + r); bus4.writedata = data;
            bus4.chipselect = 1'b1; bus4.write_n = 1'b0;
        end else begin
            bus8.address = 5'(ch * 4 + r); bus8.writedata = data;
            bus8.chipselect = 1'b1; bus8.write_n = 1'b0;
        end
        step();
        bus_idle();
    endtask

    task automatic rd(input int d, input int ch, input int r, output logic [31:0] data);
        if (d == 0) begin
            bus4.address = 4'(ch * 4 + r); bus4.chipselect = 1'b1; bus4.write_n = 1'b1;
        end else begin
            bus8.address = 5'(ch * 4 + r); bus8.chipselect = 1'b1; bus8.write_n = 1'b1;
        end
        step();
        data = (d == 0) ? bus4.readdata : bus8.readdata;
        bus_idle();
    endtask

    // Reference model: e clock edges after the RUN edge, ticks = e/(P+1);
    // the first timeout happens on tick N+1, then every N+1 ticks.
    function automatic int m_ticks(input int e, input int p);
        return e / (p + 1);
    endfunction

    function automatic bit m_to(input int e, input int n, input int p);
        return m_ticks(e, p) >= n + 1;
    endfunction

    function automatic bit m_run(input int e, input int n, input int p, input bit cont);
        return cont || (m_ticks(e, p) < n + 1);
    endfunction

    function automatic int m_count(input int e, input int n, input int p, input bit cont);
        int t;
        t = m_ticks(e, p);
        if (!cont && t >= n + 1) return n;
        return n - (t % (n + 1));
    endfunction

    initial begin
        logic [31:0] v;
        int run_edge;
        int r0;
        int r7;
        logic [7:0] exp8;

        bus4.address = 4'd2; bus4.writedata = '0;
        bus8.address = 5'd0; bus8.writedata = '0;
        bus_idle();

        // ---------------- reset ----------------
        reset = 1'b1;
        repeat (3) step();
        check("reset_readdata", bus4.readdata, 32'd0);
        check("reset_irq_vec", 32'(irq_vec4), 32'd0);
        check("reset_irq", 32'(irq4), 32'd0);
        reset = 1'b0;
        step();

        rd(0, 0, REG_PERIOD, v);  check("reset_period_ch0", v, 32'd99999);
        rd(0, 0, REG_STATUS, v);  check("reset_status_ch0", v, 32'd0);
        rd(0, 0, REG_SNAP, v);    check("reset_snap_ch0", v, 32'd0);
        rd(0, 0, REG_CONTROL, v); check("reset_control_ch0", v, 32'd0);

        // ---------------- continuous mode, ch1 ----------------
        wr(0, 1, REG_PERIOD, 32'd9);
        wr(0, 1, REG_CONTROL, 32'h7);   // CONT|ITO|START
        run_edge = cyc;
        rd(0, 1, REG_CONTROL, v); check("ctrl_start_selfclear", v, 32'h3);
        wait_until(run_edge + 9);
        check("cont_irq_before", 32'(irq_vec4[1]), 32'd0);
        step();
        check("cont_irq_at10", 32'(irq_vec4[1]), 32'd1);
        check("cont_irq_or", 32'(irq4), 32'd1);
        wait_until(run_edge + 15);
        wr(0, 1, REG_STATUS, 32'd0);
        check("status_clears_irq", 32'(irq_vec4[1]), 32'd0);
        wait_until(run_edge + 19);
        check("cont_irq_before20", 32'(irq_vec4[1]), 32'd0);
        step();
        check("cont_irq_at20", 32'(irq_vec4[1]), 32'd1);

        // ---------------- STATUS write on the timeout edge ----------------
        wait_until(run_edge + 25);
        wr(0, 1, REG_STATUS, 32'd0);
        wait_until(run_edge + 29);
        wr(0, 1, REG_STATUS, 32'd0);    // lands on the edge of timeout #3
        check("collision_irq", 32'(irq_vec4[1]), 32'd1);
        rd(0, 1, REG_STATUS, v); check("collision_status", v, 32'h3);
        wr(0, 1, REG_CONTROL, 32'h8);   // STOP, ITO=0
        check("ito0_drops_irq", 32'(irq_vec4[1]), 32'd0);
        wr(0, 1, REG_STATUS, 32'd0);
        rd(0, 1, REG_STATUS, v); check("stop_status", v, 32'd0);

        // ---------------- one-shot with prescaler, ch2 ----------------
        wr(0, 2, REG_PERIOD, 32'd3);
        wr(0, 2, REG_CONTROL, 32'h405); // PRESCALE=4, ITO, START
        run_edge = cyc;
        wait_until(run_edge + 19);
        check("oneshot_before", 32'(irq_vec4[2]), 32'd0);
        step();
        check("oneshot_at20", 32'(irq_vec4[2]), 32'd1);
        rd(0, 2, REG_STATUS, v); check("oneshot_status", v, 32'h1);
        wr(0, 2, REG_SNAP, 32'd0);
        rd(0, 2, REG_SNAP, v); check("oneshot_reload", v, 32'd3);
        wr(0, 2, REG_STATUS, 32'd0);
        check("oneshot_irq_clear", 32'(irq4), 32'd0);

        // ---------------- snapshot, ch0 ----------------
        wr(0, 0, REG_PERIOD, 32'd1000);
        wr(0, 0, REG_CONTROL, 32'h4);
        run_edge = cyc;
        wait_until(run_edge + 100);
        wr(0, 0, REG_SNAP, 32'd0);
        rd(0, 0, REG_SNAP, v); check("snap_900", v, 32'd900);
        wr(0, 0, REG_PERIOD, 32'd50);
        rd(0, 0, REG_STATUS, v); check("period_wr_stops", v, 32'd0);
        wr(0, 0, REG_SNAP, 32'd0);
        rd(0, 0, REG_SNAP, v); check("period_wr_count", v, 32'd50);
        rd(0, 0, REG_PERIOD, v); check("period_readback", v, 32'd50);

        // ---------------- randomized channels vs model ----------------
        for (int it = 0; it < 8; it++) begin
            int ch, n, p, w, e;
            bit cont, ito;
            ch   = $urandom_range(0, 3);
            n    = $urandom_range(0, 12);
            p    = $urandom_range(0, 3);
            cont = 1'($urandom_range(0, 1));
            ito  = 1'($urandom_range(0, 1));
            w    = $urandom_range(0, 80);
            wr(0, ch, REG_PERIOD, 32'(n));
            wr(0, ch, REG_STATUS, 32'd0);
            wr(0, ch, REG_CONTROL, (32'(p) << 8) | 32'h4 | (32'(cont) << 1) | 32'(ito));
            run_edge = cyc;
            wait_until(run_edge + w);
            e = cyc - run_edge;
            check($sformatf("rnd%0d_irq", it), 32'(irq_vec4[ch]), 32'(ito & m_to(e, n, p)));
            wr(0, ch, REG_SNAP, 32'd0);
            e = cyc - 1 - run_edge;
            rd(0, ch, REG_SNAP, v);
            check($sformatf("rnd%0d_snap", it), v, 32'(m_count(e, n, p, cont)));
            e = cyc - 1 - run_edge;
            rd(0, ch, REG_STATUS, v);
            check($sformatf("rnd%0d_status", it), v,
                  (32'(m_run(e, n, p, cont)) << 1) | 32'(m_to(e, n, p)));
            rd(0, ch, REG_CONTROL, v);
            check($sformatf("rnd%0d_control", it), v,
                  (32'(p) << 8) | (32'(cont) << 1) | 32'(ito));
        end

        // ---------------- 8 channels, 16-bit: isolation and independent IRQs ----------------
        wr(1, 7, REG_PERIOD, 32'd6);
        rd(1, 6, REG_PERIOD, v); check("iso_ch6_period", v, 32'd1000);
        rd(1, 0, REG_PERIOD, v); check("iso_ch0_period", v, 32'd1000);
        rd(1, 7, REG_PERIOD, v); check("ch7_period", v, 32'd6);
        rd(1, 6, REG_STATUS, v); check("iso_ch6_status", v, 32'd0);
        wr(1, 0, REG_PERIOD, 32'd4);
        wr(1, 0, REG_CONTROL, 32'h7);
        r0 = cyc;
        wr(1, 7, REG_CONTROL, 32'h7);
        r7 = cyc;
        for (int k = 0; k < 24; k++) begin
            exp8 = '0;
            exp8[0] = m_to(cyc - r0, 4, 0);
            exp8[7] = m_to(cyc - r7, 6, 0);
            check($sformatf("multi_vec_%0d", k), 32'(irq_vec8), 32'(exp8));
            check($sformatf("multi_irq_%0d", k), 32'(irq8), 32'(exp8 != 0));
            step();
        end
        wr(1, 0, REG_STATUS, 32'd0);
        check("multi_ch0_clear_keeps_ch7", 32'(irq_vec8), 32'h80);

        // ---------------- reset mid-count ----------------
        wr(0, 3, REG_PERIOD, 32'd2);
        wr(0, 3, REG_CONTROL, 32'h7);
        repeat (5) step();
        check("pre_reset_irq", 32'(irq_vec4[3]), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midreset_irq_vec", 32'(irq_vec4), 32'd0);
        check("midreset_irq8", 32'(irq8), 32'd0);
        rd(0, 3, REG_STATUS, v); check("midreset_status", v, 32'd0);
        rd(0, 3, REG_PERIOD, v); check("midreset_period", v, 32'd99999);
        rd(1, 7, REG_PERIOD, v); check("midreset_period8", v, 32'd1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
